// File: rtl/gpu_mem_pkg.sv
// Shared types and sizing for the 32-byte line memory writer.
package gpu_mem_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned WORDS      = 16;
    localparam int unsigned BEAT_WORDS = 4;
    localparam int unsigned BEATS      = WORDS / BEAT_WORDS;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned LINE_BYTES = 32;
    localparam int unsigned LINE_OFS_W = $clog2(LINE_BYTES);
    localparam int unsigned BEAT_BYTES = BEAT_WORDS * WORD_W / 8;
    localparam int unsigned BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LINE_W     = WORDS * WORD_W;
    localparam int unsigned BIT_IDX_W  = $clog2(LINE_W);
    localparam int unsigned DONE_W     = 16;

    // One combined line; word i sits at bits [i*WORD_W +: WORD_W].
    typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

    // FIFO payload: line-aligned byte address plus the line itself.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        line_t             line;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/gpu_mem_line_fifo.sv
// Small line FIFO with registered occupancy count; no bypass paths.
module gpu_mem_line_fifo
    import gpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push_i,
    input  entry_t                       push_entry_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Pointer wrap modulo DEPTH and occupancy update.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_i) begin
            wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the queue.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Payload storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/gpu_mem_line_writer.sv
// Buffers combined 32B lines and streams each as narrow memory write beats.
module gpu_mem_line_writer
    import gpu_mem_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         io_in_valid,
    output logic                         io_in_ready,
    input  logic [LINE_W-1:0]            io_in_data,
    input  logic [ADDR_W-1:0]            io_in_addr,
    output logic                         io_mem_valid,
    input  logic                         io_mem_ready,
    output logic [ADDR_W-1:0]            io_mem_addr,
    output logic [BEAT_WORDS*WORD_W-1:0] io_mem_data,
    output logic                         io_mem_last,
    output logic                         io_misaligned,
    output logic [DONE_W-1:0]            io_lines_done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                   push, pop, full, empty;
    logic                   beat_hs, last_beat;
    logic [CNT_W-1:0]       count;
    entry_t                 push_entry, head;
    logic [LINE_W-1:0]      head_flat;
    logic [BIT_IDX_W-1:0]   bit_base;

    state_e                 state_q, state_d;
    logic [BEAT_CNT_W-1:0]  beat_q, beat_d;
    logic                   misaligned_q;
    logic [DONE_W-1:0]      lines_done_q;

    assign io_in_ready     = !full;
    assign push            = io_in_valid && !full;
    assign push_entry.addr = {io_in_addr[ADDR_W-1:LINE_OFS_W], LINE_OFS_W'(0)};
    assign push_entry.line = line_t'(io_in_data);

    assign io_mem_valid = (state_q == SEND);
    assign beat_hs      = io_mem_valid && io_mem_ready;
    assign last_beat    = (beat_q == BEAT_CNT_W'(BEATS - 1));
    assign pop          = beat_hs && last_beat;

    gpu_mem_line_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count)
    );

    // Output-side FSM and beat counter next-state.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (push || !empty) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat_hs) begin
                    beat_d = last_beat ? '0 : beat_q + BEAT_CNT_W'(1);
                end
                if (pop && !push && (count == CNT_W'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, beat counter, misalign pulse and completed-line counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            misaligned_q <= 1'b0;
            lines_done_q <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            misaligned_q <= push && (io_in_addr[LINE_OFS_W-1:0] != '0);
            lines_done_q <= lines_done_q + DONE_W'(pop);
        end
    end

    // Beat mux: select words k*BEAT_WORDS.. of the head line.
    assign head_flat   = head.line;
    assign bit_base    = BIT_IDX_W'(beat_q) * BIT_IDX_W'(BEAT_WORDS * WORD_W);
    assign io_mem_data = head_flat[bit_base +: BEAT_WORDS*WORD_W];
    assign io_mem_addr = head.addr + ADDR_W'(beat_q) * ADDR_W'(BEAT_BYTES);
    assign io_mem_last = io_mem_valid && last_beat;

    assign io_misaligned = misaligned_q;
    assign io_lines_done = lines_done_q;

endmodule

// File: tb/tb_gpu_mem_line_writer.sv
// Directed bench for gpu_mem_line_writer.
module tb_gpu_mem_line_writer;
    import gpu_mem_pkg::*;

    logic                         clock = 1'b0;
    logic                         reset;
    logic                         io_in_valid;
    logic                         io_in_ready;
    logic [LINE_W-1:0]            io_in_data;
    logic [ADDR_W-1:0]            io_in_addr;
    logic                         io_mem_valid;
    logic                         io_mem_ready;
    logic [ADDR_W-1:0]            io_mem_addr;
    logic [BEAT_WORDS*WORD_W-1:0] io_mem_data;
    logic                         io_mem_last;
    logic                         io_misaligned;
    logic [DONE_W-1:0]            io_lines_done;

    int n_checks = 0;
    int n_fail   = 0;

    gpu_mem_line_writer dut (
        .clock         (clock),
        .reset         (reset),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_data    (io_in_data),
        .io_in_addr    (io_in_addr),
        .io_mem_valid  (io_mem_valid),
        .io_mem_ready  (io_mem_ready),
        .io_mem_addr   (io_mem_addr),
        .io_mem_data   (io_mem_data),
        .io_mem_last   (io_mem_last),
        .io_misaligned (io_misaligned),
        .io_lines_done (io_lines_done)
    );

    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Line whose word i is base+i.
    function automatic logic [LINE_W-1:0] mk_line(input logic [15:0] base);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 16; i++) l[i*16 +: 16] = base + 16'(i);
        return l;
    endfunction

    // Expected beat k of a line built by mk_line.
    function automatic logic [63:0] beat_of(input logic [15:0] base, input int k);
        logic [15:0] w0;
        w0 = base + 16'(4 * k);
        return {w0 + 16'd3, w0 + 16'd2, w0 + 16'd1, w0};
    endfunction

    task automatic test_reset;
        reset = 1'b1; io_in_valid = 1'b0; io_in_data = '0; io_in_addr = '0; io_mem_ready = 1'b0;
        step; step;
        reset = 1'b0;
        n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", io_in_ready); end
        n_checks++; if (io_mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b exp 0", io_mem_valid); end
        n_checks++; if (io_mem_last !== 1'b0) begin n_fail++; $display("FAIL reset_mem_last got %b exp 0", io_mem_last); end
        n_checks++; if (io_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got %b exp 0", io_misaligned); end
        n_checks++; if (io_lines_done !== 16'd0) begin n_fail++; $display("FAIL reset_lines_done got %h exp 0", io_lines_done); end
    endtask

    task automatic test_single_line;
        io_mem_ready = 1'b1;
        io_in_data = mk_line(16'h1100); io_in_addr = 32'h1000; io_in_valid = 1'b1;
        n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got %b exp 1", io_in_ready); end
        step;
        io_in_valid = 1'b0;
        n_checks++; if (io_mem_data !== 64'h1103_1102_1101_1100) begin n_fail++; $display("FAIL single_beat0_data got %h exp 1103110211011100", io_mem_data); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (io_mem_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid beat %0d got %b exp 1", k, io_mem_valid); end
            n_checks++; if (io_mem_addr !== 32'h1000 + 32'(8 * k)) begin n_fail++; $display("FAIL single_addr beat %0d got %h exp %h", k, io_mem_addr, 32'h1000 + 32'(8 * k)); end
            n_checks++; if (io_mem_data !== beat_of(16'h1100, k)) begin n_fail++; $display("FAIL single_data beat %0d got %h exp %h", k, io_mem_data, beat_of(16'h1100, k)); end
            n_checks++; if (io_mem_last !== (k == 3)) begin n_fail++; $display("FAIL single_last beat %0d got %b exp %b", k, io_mem_last, (k == 3)); end
            step;
        end
        n_checks++; if (io_mem_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b exp 0", io_mem_valid); end
        n_checks++; if (io_lines_done !== 16'd1) begin n_fail++; $display("FAIL single_lines_done got %h exp 1", io_lines_done); end
    endtask

    task automatic test_backpressure;
        logic [3:0] pat;
        int k;
        int cyc;
        pat = 4'b1001;
        io_mem_ready = 1'b0;
        io_in_data = mk_line(16'h2200); io_in_addr = 32'h3000; io_in_valid = 1'b1;
        step;
        io_in_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < 4 && cyc < 40) begin
            io_mem_ready = pat[cyc % 4];
            if (io_mem_valid) begin
                n_checks++; if (io_mem_addr !== 32'h3000 + 32'(8 * k)) begin n_fail++; $display("FAIL bp_addr beat %0d got %h exp %h", k, io_mem_addr, 32'h3000 + 32'(8 * k)); end
                n_checks++; if (io_mem_data !== beat_of(16'h2200, k)) begin n_fail++; $display("FAIL bp_data beat %0d got %h exp %h", k, io_mem_data, beat_of(16'h2200, k)); end
                n_checks++; if (io_mem_last !== (k == 3)) begin n_fail++; $display("FAIL bp_last beat %0d got %b exp %b", k, io_mem_last, (k == 3)); end
                if (io_mem_ready) k++;
            end
            cyc++;
            step;
        end
        n_checks++; if (k !== 4) begin n_fail++; $display("FAIL bp_beat_count got %0d exp 4", k); end
        n_checks++; if (io_mem_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra_beat got %b exp 0", io_mem_valid); end
        n_checks++; if (io_lines_done !== 16'd2) begin n_fail++; $display("FAIL bp_lines_done got %h exp 2", io_lines_done); end
    endtask

    task automatic test_full;
        logic [31:0] ea;
        io_mem_ready = 1'b0;
        io_in_data = mk_line(16'h4100); io_in_addr = 32'h4000; io_in_valid = 1'b1;
        n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_a got %b exp 1", io_in_ready); end
        step;
        io_in_data = mk_line(16'h4200); io_in_addr = 32'h4020;
        n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_b got %b exp 1", io_in_ready); end
        step;
        io_in_data = mk_line(16'h4300); io_in_addr = 32'h4040;
        n_checks++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_c got %b exp 0", io_in_ready); end
        step; step; step;
        n_checks++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_held got %b exp 0", io_in_ready); end
        n_checks++; if (io_mem_valid !== 1'b1 || io_mem_addr !== 32'h4000) begin n_fail++; $display("FAIL full_stall_head got v=%b a=%h exp v=1 a=4000", io_mem_valid, io_mem_addr); end
        n_checks++; if (io_mem_data !== beat_of(16'h4100, 0)) begin n_fail++; $display("FAIL full_stall_data got %h exp %h", io_mem_data, beat_of(16'h4100, 0)); end
        io_mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_bypass beat %0d got %b exp 0", k, io_in_ready); end
            n_checks++; if (io_mem_addr !== 32'h4000 + 32'(8 * k)) begin n_fail++; $display("FAIL full_a_addr beat %0d got %h exp %h", k, io_mem_addr, 32'h4000 + 32'(8 * k)); end
            step;
        end
        n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise got %b exp 1", io_in_ready); end
        n_checks++; if (io_mem_valid !== 1'b1 || io_mem_addr !== 32'h4020) begin n_fail++; $display("FAIL full_b_start got v=%b a=%h exp v=1 a=4020", io_mem_valid, io_mem_addr); end
        step;
        io_in_valid = 1'b0;
        for (int j = 0; j < 7; j++) begin
            ea = (j < 3) ? 32'h4020 + 32'(8 * (j + 1)) : 32'h4040 + 32'(8 * (j - 3));
            n_checks++; if (io_mem_valid !== 1'b1 || io_mem_addr !== ea) begin n_fail++; $display("FAIL full_drain step %0d got v=%b a=%h exp v=1 a=%h", j, io_mem_valid, io_mem_addr, ea); end
            if (j == 3) begin
                n_checks++; if (io_mem_data !== beat_of(16'h4300, 0)) begin n_fail++; $display("FAIL full_c_data got %h exp %h", io_mem_data, beat_of(16'h4300, 0)); end
            end
            step;
        end
        n_checks++; if (io_mem_valid !== 1'b0) begin n_fail++; $display("FAIL full_idle got %b exp 0", io_mem_valid); end
        n_checks++; if (io_lines_done !== 16'd5) begin n_fail++; $display("FAIL full_lines_done got %h exp 5", io_lines_done); end
    endtask

    task automatic test_misaligned;
        io_mem_ready = 1'b1;
        n_checks++; if (io_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pre got %b exp 0", io_misaligned); end
        io_in_data = mk_line(16'h3300); io_in_addr = 32'h2013; io_in_valid = 1'b1;
        step;
        io_in_valid = 1'b0;
        n_checks++; if (io_misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got %b exp 1", io_misaligned); end
        n_checks++; if (io_mem_addr !== 32'h2000) begin n_fail++; $display("FAIL mis_addr0 got %h exp 2000", io_mem_addr); end
        n_checks++; if (io_mem_data !== beat_of(16'h3300, 0)) begin n_fail++; $display("FAIL mis_data0 got %h exp %h", io_mem_data, beat_of(16'h3300, 0)); end
        step;
        n_checks++; if (io_misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle got %b exp 0", io_misaligned); end
        n_checks++; if (io_mem_addr !== 32'h2008) begin n_fail++; $display("FAIL mis_addr1 got %h exp 2008", io_mem_addr); end
        step; step;
        n_checks++; if (io_mem_last !== 1'b1 || io_mem_addr !== 32'h2018) begin n_fail++; $display("FAIL mis_last got l=%b a=%h exp l=1 a=2018", io_mem_last, io_mem_addr); end
        step;
        n_checks++; if (io_lines_done !== 16'd6) begin n_fail++; $display("FAIL mis_lines_done got %h exp 6", io_lines_done); end
    endtask

    task automatic test_reset_mid_line;
        io_mem_ready = 1'b0;
        io_in_data = mk_line(16'h5500); io_in_addr = 32'h5000; io_in_valid = 1'b1;
        step;
        io_in_data = mk_line(16'h5600); io_in_addr = 32'h5020;
        step;
        io_in_valid = 1'b0;
        io_mem_ready = 1'b1;
        step; step;
        n_checks++; if (io_mem_addr !== 32'h5010) begin n_fail++; $display("FAIL rst_mid_pre got %h exp 5010", io_mem_addr); end
        io_mem_ready = 1'b0;
        reset = 1'b1;
        step;
        reset = 1'b0;
        n_checks++; if (io_mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b exp 0", io_mem_valid); end
        n_checks++; if (io_lines_done !== 16'd0) begin n_fail++; $display("FAIL rst_mid_lines got %h exp 0", io_lines_done); end
        n_checks++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b exp 1", io_in_ready); end
        step; step; step;
        n_checks++; if (io_mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_resume got %b exp 0", io_mem_valid); end
        io_mem_ready = 1'b1;
        io_in_data = mk_line(16'h6600); io_in_addr = 32'h6000; io_in_valid = 1'b1;
        step;
        io_in_valid = 1'b0;
        n_checks++; if (io_mem_addr !== 32'h6000 || io_mem_last !== 1'b0) begin n_fail++; $display("FAIL rst_new_beat0 got a=%h l=%b exp a=6000 l=0", io_mem_addr, io_mem_last); end
        n_checks++; if (io_mem_data !== beat_of(16'h6600, 0)) begin n_fail++; $display("FAIL rst_new_data got %h exp %h", io_mem_data, beat_of(16'h6600, 0)); end
        step; step; step; step;
        n_checks++; if (io_mem_valid !== 1'b0 || io_lines_done !== 16'd1) begin n_fail++; $display("FAIL rst_new_done got v=%b n=%h exp v=0 n=1", io_mem_valid, io_lines_done); end
    endtask

    task automatic test_counter_wrap;
        io_mem_ready = 1'b1;
        force dut.lines_done_q = 16'hFFFF;
        step;
        release dut.lines_done_q;
        step;
        n_checks++; if (io_lines_done !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got %h exp ffff", io_lines_done); end
        io_in_data = mk_line(16'h7700); io_in_addr = 32'h7000; io_in_valid = 1'b1;
        step;
        io_in_valid = 1'b0;
        step; step; step;
        n_checks++; if (io_lines_done !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_before_last got %h exp ffff", io_lines_done); end
        step;
        n_checks++; if (io_lines_done !== 16'h0000) begin n_fail++; $display("FAIL wrap_to_zero got %h exp 0000", io_lines_done); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_single_line;
        test_backpressure;
        test_full;
        test_misaligned;
        test_reset_mid_line;
        test_counter_wrap;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
